matmul_apb_initiator: RTL and testbench
=======================================

Name: matmul_apb_initiator

Overview:
- APB initiator that drives the matmul accelerator's APB target port.
- Accepts read/write commands on a valid/ready interface and buffers them in a small command FIFO.
- Executes each command as one APB transfer (SETUP then ACCESS) and returns read data and error status on a response valid/ready interface.
- Used as the bus-side driver in the system wrapper and as the stimulus engine for the matmul bench.

Parameters:
- BUS_WIDTH, 32, APB data width; must match the accelerator bus width.
- ADDR_WIDTH, 16, APB address width.
- CMD_DEPTH, 4, command FIFO entries; power of two, at least 2.
- TIMEOUT_CYC, 16, maximum ACCESS cycles waiting for pready_i before forced error.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  asynchronous reset, active low.
- cmd_valid_i  in  1  command present.
- cmd_ready_o  out  1  command FIFO not full.
- cmd_write_i  in  1  1 = write, 0 = read.
- cmd_addr_i  in  ADDR_WIDTH  target address.
- cmd_wdata_i  in  BUS_WIDTH  write data.
- cmd_strb_i  in  BUS_WIDTH/8  byte strobes; ignored for reads.
- rsp_valid_o  out  1  response present.
- rsp_ready_i  in  1  response consumed.
- rsp_rdata_o  out  BUS_WIDTH  read data; 0 for writes and for errors.
- rsp_err_o  out  1  pslverr_i or timeout.
- psel_o, penable_o, pwrite_o  out  1 each  APB control.
- paddr_o  out  ADDR_WIDTH  APB address.
- pwdata_o  out  BUS_WIDTH  APB write data.
- pstrb_o  out  BUS_WIDTH/8  APB strobes; forced to 0 on reads.
- pready_i, pslverr_i  in  1 each  APB target completion and error.
- prdata_i  in  BUS_WIDTH  APB read data.
- busy_o  out  1  FIFO non-empty or FSM not in IDLE.

Behaviour:
- Reset (async, rst_ni = 0):
  - FIFO empty, FSM in IDLE, timeout counter cleared.
  - Outputs: psel_o, penable_o, pwrite_o, rsp_valid_o, rsp_err_o, busy_o all 0; paddr_o, pwdata_o, pstrb_o, rsp_rdata_o all 0; cmd_ready_o = 1.
  - Reset asserted mid-transfer drops psel_o/penable_o immediately. Queued commands and any pending response are discarded.
- Command FIFO:
  - Push when cmd_valid_i && cmd_ready_o; cmd_ready_o = !full.
  - Pop occurs on the IDLE->SETUP transition.
  - Push and pop in the same cycle are both honoured; occupancy is unchanged.
  - When full, cmd_ready_o = 0; a pop in that cycle does not raise ready until the next cycle.
  - Read/write pointers wrap modulo CMD_DEPTH.
- FSM, states IDLE, SETUP, ACCESS, RESP:
  - IDLE: if FIFO non-empty, pop the head into the transfer register -> SETUP. Otherwise stay in IDLE.
  - SETUP (exactly 1 cycle): psel_o = 1, penable_o = 0; paddr_o, pwrite_o, pwdata_o, pstrb_o driven from the transfer register -> ACCESS.
  - ACCESS: psel_o = 1, penable_o = 1, address/data held stable.
    - On pready_i = 1, capture rsp_err_o = pslverr_i and rsp_rdata_o = (read && !pslverr_i) ? prdata_i : 0 -> RESP.
    - If TIMEOUT_CYC ACCESS cycles pass without pready_i, capture rsp_err_o = 1 and rsp_rdata_o = 0 -> RESP.
  - RESP: psel_o = 0, penable_o = 0, rsp_valid_o = 1, response held stable. On rsp_ready_i = 1 -> IDLE, or -> SETUP directly (with pop) if the FIFO is non-empty.
- Latency: a command pushed into an empty FIFO on edge N drives SETUP during cycle N+1. With zero-wait pready_i, rsp_valid_o rises in cycle N+3.
- With continuous rsp_ready_i, back-to-back transfers take 3 cycles each.
- Only one transfer is outstanding at a time; responses are returned in command order.
- The timeout counter clears on entry to ACCESS and saturates.
- pready_i and pslverr_i are ignored outside ACCESS.

Test Plan:
- Reset, then idle for 5 cycles -> all APB outputs 0, cmd_ready_o = 1, busy_o = 0.
- Write addr 0x0010, data 0x0403_0201, strb 0xF, zero wait -> SETUP then ACCESS visible, pstrb_o = 0xF, response err = 0 and rdata = 0 three cycles after push.
- Read addr 0x0020, target returns prdata 0xDEAD_BEEF after 2 wait cycles -> penable_o held 3 cycles, rsp_rdata_o = 0xDEAD_BEEF, pstrb_o = 0.
- Push 5 commands back-to-back with CMD_DEPTH = 4 and target stalled -> cmd_ready_o drops after the 4th FIFO entry. After the stall releases, all 5 responses return in order with no lost or duplicated transfer.
- Target never asserts pready_i -> exactly 16 ACCESS cycles, then rsp_err_o = 1 and rsp_rdata_o = 0. Read with pslverr_i = 1 -> rsp_err_o = 1, rsp_rdata_o = 0.
- Assert rst_ni low during ACCESS with 2 commands queued -> psel_o drops the same cycle. After release, no transfer is issued and busy_o = 0.

Source files
------------

// File: rtl/matmul_apb_initiator_if.sv
// Command, response and APB signal bundle for the matmul APB initiator.
// The initiator uses the master modport; the command source, response sink and APB target use slave.
interface matmul_apb_initiator_if #(
  parameter int BUS_WIDTH  = 32,
  parameter int ADDR_WIDTH = 16
);
  localparam int STRB_W = BUS_WIDTH / 8;

  logic                  cmd_valid_i;
  logic                  cmd_ready_o;
  logic                  cmd_write_i;
  logic [ADDR_WIDTH-1:0] cmd_addr_i;
  logic [BUS_WIDTH-1:0]  cmd_wdata_i;
  logic [STRB_W-1:0]     cmd_strb_i;

  logic                  rsp_valid_o;
  logic                  rsp_ready_i;
  logic [BUS_WIDTH-1:0]  rsp_rdata_o;
  logic                  rsp_err_o;

  logic                  psel_o;
  logic                  penable_o;
  logic                  pwrite_o;
  logic [ADDR_WIDTH-1:0] paddr_o;
  logic [BUS_WIDTH-1:0]  pwdata_o;
  logic [STRB_W-1:0]     pstrb_o;
  logic                  pready_i;
  logic                  pslverr_i;
  logic [BUS_WIDTH-1:0]  prdata_i;

  logic                  busy_o;

  modport master (
    input  cmd_valid_i, cmd_write_i, cmd_addr_i, cmd_wdata_i, cmd_strb_i,
    input  rsp_ready_i, pready_i, pslverr_i, prdata_i,
    output cmd_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
    output psel_o, penable_o, pwrite_o, paddr_o, pwdata_o, pstrb_o, busy_o
  );

  modport slave (
    output cmd_valid_i, cmd_write_i, cmd_addr_i, cmd_wdata_i, cmd_strb_i,
    output rsp_ready_i, pready_i, pslverr_i, prdata_i,
    input  cmd_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
    input  psel_o, penable_o, pwrite_o, paddr_o, pwdata_o, pstrb_o, busy_o
  );
endinterface

// File: rtl/matmul_apb_initiator.sv
// APB initiator: buffers read/write commands in a small FIFO and runs each one
// as a single SETUP/ACCESS transfer, returning data and error on a response handshake.
module matmul_apb_initiator #(
  parameter int BUS_WIDTH   = 32,
  parameter int ADDR_WIDTH  = 16,
  parameter int CMD_DEPTH   = 4,
  parameter int TIMEOUT_CYC = 16
) (
  input logic                     clk_i,
  input logic                     rst_ni,
  matmul_apb_initiator_if.master  bus
);
  localparam int STRB_W = BUS_WIDTH / 8;
  localparam int PTR_W  = $clog2(CMD_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int TMO_W  = $clog2(TIMEOUT_CYC + 1);

  typedef struct packed {
    logic                  write;
    logic [ADDR_WIDTH-1:0] addr;
    logic [BUS_WIDTH-1:0]  wdata;
    logic [STRB_W-1:0]     strb;
  } cmd_t;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_e;

  cmd_t                 fifo_mem_q [CMD_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;
  state_e               state_q, state_d;
  cmd_t                 xfer_q, xfer_d;
  logic [TMO_W-1:0]     tmo_q, tmo_d;
  logic [BUS_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                 rsp_err_q, rsp_err_d;

  logic full, empty, push, pop;
  cmd_t cmd_in, head;

  assign full   = (count_q == CNT_W'(CMD_DEPTH));
  assign empty  = (count_q == '0);
  assign push   = bus.cmd_valid_i && !full;
  assign cmd_in = '{write: bus.cmd_write_i, addr: bus.cmd_addr_i,
                    wdata: bus.cmd_wdata_i, strb: bus.cmd_strb_i};
  assign head   = fifo_mem_q[rd_ptr_q];

  // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_d     = state_q;
    xfer_d      = xfer_q;
    tmo_d       = tmo_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    pop         = 1'b0;

    unique case (state_q)
      IDLE:   pop = !empty;
      SETUP: begin
        state_d = ACCESS;
        tmo_d   = '0;
      end
      ACCESS: begin
        if (bus.pready_i) begin
          rsp_err_d   = bus.pslverr_i;
          rsp_rdata_d = (!xfer_q.write && !bus.pslverr_i) ? bus.prdata_i : '0;
          state_d     = RESP;
        end else if (tmo_q == TMO_W'(TIMEOUT_CYC - 1)) begin
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
          state_d     = RESP;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      RESP: begin
        if (bus.rsp_ready_i) begin
          state_d = IDLE;
          pop     = !empty;
        end
      end
      default: state_d = IDLE;
    endcase

    // Popping always launches a transfer; read strobes are zeroed once here.
    if (pop) begin
      xfer_d  = head;
      state_d = SETUP;
      if (!head.write) xfer_d.strb = '0;
    end
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
  end

  // NOTE: asynchronous active-low reset; all state flops use non-blocking assignments.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      xfer_q      <= '0;
      tmo_q       <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      xfer_q      <= xfer_d;
      tmo_q       <= tmo_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // NOTE: FIFO storage is not reset; the occupancy count alone decides which entries are valid.
  always_ff @(posedge clk_i) begin
    if (push) fifo_mem_q[wr_ptr_q] <= cmd_in;
  end

  logic sel;
  assign sel = (state_q == SETUP) || (state_q == ACCESS);

  assign bus.psel_o      = sel;
  assign bus.penable_o   = (state_q == ACCESS);
  assign bus.pwrite_o    = sel && xfer_q.write;
  assign bus.paddr_o     = sel ? xfer_q.addr  : '0;
  assign bus.pwdata_o    = sel ? xfer_q.wdata : '0;
  assign bus.pstrb_o     = sel ? xfer_q.strb  : '0;

  assign bus.cmd_ready_o = !full;
  assign bus.rsp_valid_o = (state_q == RESP);
  assign bus.rsp_rdata_o = rsp_rdata_q;
  assign bus.rsp_err_o   = rsp_err_q;
  assign bus.busy_o      = !empty || (state_q != IDLE);

endmodule

// File: tb/tb_matmul_apb_initiator.sv
// Self-checking bench for matmul_apb_initiator: APB target model plus an
// in-order response scoreboard fed as commands are accepted.
module tb_matmul_apb_initiator;
  localparam int BW = 32;
  localparam int AW = 16;

  typedef struct {
    logic          err;
    logic [BW-1:0] rdata;
  } exp_t;

  logic clk_i  = 1'b0;
  logic rst_ni = 1'b0;

  matmul_apb_initiator_if #(.BUS_WIDTH(BW), .ADDR_WIDTH(AW)) bus ();

  matmul_apb_initiator #(
    .BUS_WIDTH(BW), .ADDR_WIDTH(AW), .CMD_DEPTH(4), .TIMEOUT_CYC(16)
  ) dut (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .bus   (bus)
  );

  always #5 clk_i = ~clk_i;

  int   n_checks = 0;
  int   n_pass   = 0;
  exp_t sb[$];

  // Target behaviour knobs.
  int   tgt_wait = 0;
  logic tgt_hold = 1'b0;
  logic tgt_dead = 1'b0;
  logic tgt_err  = 1'b0;
  logic rand_rdy = 1'b0;

  int acc_cnt       = 0;
  int acc_run       = 0;
  int last_acc_len  = 0;
  int psel_cnt      = 0;
  int rsp_cnt       = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [BW-1:0] tgt_data(input logic [AW-1:0] a);
    return (a == 16'h0020) ? 32'hDEAD_BEEF : {a ^ 16'h5A5A, a};
  endfunction

  // APB target: junk on pready/pslverr/prdata outside ACCESS, which the DUT must ignore.
  always begin
    @(posedge clk_i);
    #1;
    if (bus.psel_o && bus.penable_o) begin
      bus.pready_i  = !tgt_hold && !tgt_dead && (acc_cnt >= tgt_wait);
      bus.pslverr_i = tgt_err;
      bus.prdata_i  = tgt_data(bus.paddr_o);
      acc_cnt++;
    end else begin
      bus.pready_i  = 1'b1;
      bus.pslverr_i = 1'b1;
      bus.prdata_i  = 32'hBAD0_BAD0;
      acc_cnt       = 0;
    end
  end

  always begin
    @(posedge clk_i);
    #1;
    if (rand_rdy) bus.rsp_ready_i = 1'($urandom_range(0, 1));
  end

  // Monitor: ACCESS run lengths, psel activity and scoreboard comparison.
  always @(negedge clk_i) begin
    if (bus.psel_o) psel_cnt++;
    if (bus.penable_o) acc_run++;
    else if (acc_run != 0) begin
      last_acc_len = acc_run;
      acc_run      = 0;
    end
    if (rst_ni && bus.rsp_valid_o && bus.rsp_ready_i) begin
      rsp_cnt++;
      if (sb.size() == 0) check("rsp_unexpected", 1, 0);
      else begin
        exp_t e;
        e = sb.pop_front();
        check("rsp_err", bus.rsp_err_o, e.err);
        check("rsp_rdata", bus.rsp_rdata_o, e.rdata);
      end
    end
  end

  task automatic send(input logic w, input logic [AW-1:0] a, input logic [BW-1:0] d,
                      input logic [3:0] s);
    bit   accepted = 0;
    exp_t e;
    bus.cmd_valid_i = 1'b1;
    bus.cmd_write_i = w;
    bus.cmd_addr_i  = a;
    bus.cmd_wdata_i = d;
    bus.cmd_strb_i  = s;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk_i);
      if (bus.cmd_ready_o) begin
        accepted = 1;
        break;
      end
      @(posedge clk_i);
      #1;
    end
    if (accepted) begin
      if (tgt_dead || tgt_err) e = '{err: 1'b1, rdata: '0};
      else if (w)              e = '{err: 1'b0, rdata: '0};
      else                     e = '{err: 1'b0, rdata: tgt_data(a)};
      sb.push_back(e);
      @(posedge clk_i);
      #1;
    end else begin
      check("cmd_accept", 0, 1);
    end
    bus.cmd_valid_i = 1'b0;
  endtask

  task automatic drain(input int budget);
    bit done = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk_i);
      if (sb.size() == 0 && !bus.busy_o) begin
        done = 1;
        break;
      end
    end
    check("drain_done", done, 1);
  endtask

  initial begin
    int psel_before;
    int rsp_before;
    bit saw_access;

    bus.cmd_valid_i = 1'b0;
    bus.cmd_write_i = 1'b0;
    bus.cmd_addr_i  = '0;
    bus.cmd_wdata_i = '0;
    bus.cmd_strb_i  = '0;
    bus.rsp_ready_i = 1'b1;
    bus.pready_i    = 1'b0;
    bus.pslverr_i   = 1'b0;
    bus.prdata_i    = '0;

    // Reset and idle.
    repeat (3) @(negedge clk_i);
    rst_ni = 1'b1;
    repeat (5) @(negedge clk_i);
    check("reset_apb", {bus.psel_o, bus.penable_o, bus.pwrite_o, bus.paddr_o,
                        bus.pwdata_o, bus.pstrb_o}, 0);
    check("reset_rsp", {bus.rsp_valid_o, bus.rsp_err_o, bus.rsp_rdata_o}, 0);
    check("reset_ready", bus.cmd_ready_o, 1);
    check("reset_busy", bus.busy_o, 0);

    // Zero-wait write with latency checks.
    @(posedge clk_i);
    #1;
    send(1'b1, 16'h0010, 32'h0403_0201, 4'hF);
    @(negedge clk_i);
    check("lat_idle_psel", bus.psel_o, 0);
    @(negedge clk_i);
    check("lat_setup", {bus.psel_o, bus.penable_o, bus.pwrite_o, bus.paddr_o,
                        bus.pwdata_o, bus.pstrb_o},
          {1'b1, 1'b0, 1'b1, 16'h0010, 32'h0403_0201, 4'hF});
    @(negedge clk_i);
    check("lat_access", {bus.psel_o, bus.penable_o, bus.paddr_o},
          {1'b1, 1'b1, 16'h0010});
    @(negedge clk_i);
    check("lat_rsp_valid", {bus.rsp_valid_o, bus.psel_o}, 2'b10);
    drain(20);

    // Read with two wait states; strobes must be forced to zero.
    tgt_wait = 2;
    @(posedge clk_i);
    #1;
    send(1'b0, 16'h0020, 32'h1111_2222, 4'hF);
    repeat (2) @(negedge clk_i);
    check("read_setup", {bus.psel_o, bus.penable_o, bus.pwrite_o, bus.pstrb_o},
          {1'b1, 1'b0, 1'b0, 4'h0});
    drain(30);
    check("read_access_len", last_acc_len, 3);
    tgt_wait = 0;

    // Five back-to-back commands against a stalled target.
    tgt_hold = 1'b1;
    rsp_before = rsp_cnt;
    @(posedge clk_i);
    #1;
    for (int i = 0; i < 5; i++)
      send(i[0], 16'h0100 + 16'(i * 4), 32'hC0DE_0000 + 32'(i), 4'h3);
    @(negedge clk_i);
    check("full_ready_low", bus.cmd_ready_o, 0);
    repeat (4) @(negedge clk_i);
    check("full_ready_held", {bus.cmd_ready_o, bus.penable_o}, 2'b01);
    tgt_hold = 1'b0;
    drain(60);
    check("full_rsp_count", rsp_cnt - rsp_before, 5);

    // Timeout: target never answers.
    tgt_dead = 1'b1;
    @(posedge clk_i);
    #1;
    send(1'b1, 16'h0040, 32'h5555_AAAA, 4'h1);
    drain(60);
    check("timeout_access_len", last_acc_len, 16);
    tgt_dead = 1'b0;

    // Slave error on a read.
    tgt_err = 1'b1;
    @(posedge clk_i);
    #1;
    send(1'b0, 16'h0030, 32'h0, 4'h0);
    drain(30);
    tgt_err = 1'b0;

    // Randomised commands with response backpressure.
    tgt_wait = 1;
    rand_rdy = 1'b1;
    @(posedge clk_i);
    #1;
    for (int i = 0; i < 8; i++)
      send(1'($urandom_range(0, 1)), 16'($urandom_range(0, 16'hFFFF)), $urandom, 4'hF);
    drain(400);
    rand_rdy = 1'b0;
    bus.rsp_ready_i = 1'b1;
    tgt_wait = 0;

    // Reset during ACCESS with two commands still queued.
    tgt_hold = 1'b1;
    @(posedge clk_i);
    #1;
    for (int i = 0; i < 3; i++) send(1'b1, 16'h0200 + 16'(i), 32'(i), 4'hF);
    saw_access = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_i);
      if (bus.penable_o) begin
        saw_access = 1;
        break;
      end
    end
    check("rst_reached_access", saw_access, 1);
    rst_ni = 1'b0;
    #1;
    check("rst_psel_drop", {bus.psel_o, bus.penable_o}, 0);
    check("rst_busy_clear", {bus.busy_o, bus.cmd_ready_o, bus.rsp_valid_o}, 3'b010);
    sb.delete();
    tgt_hold = 1'b0;
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    psel_before = psel_cnt;
    repeat (6) @(negedge clk_i);
    check("rst_no_transfer", psel_cnt - psel_before, 0);
    check("rst_idle", {bus.busy_o, bus.rsp_valid_o}, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
